// File: rtl/vend_credit_ctrl.sv
// ---------------------------------------------------------------------------
// vend_credit_ctrl
//
// Purpose:
//   Sequences the external 4-bit credit Register of a vending machine. It
//   accepts coins, applies item prices, dispenses items and returns change
//   one credit unit at a time. The credit value itself lives only in the
//   external Register. This block writes it through reg_d/reg_en_n and reads
//   it back through credit_q. All outputs come straight from flops (Moore).
//
// Ports:
//   clk           in   1  clock, rising edge
//   clr           in   1  asynchronous reset, active low
//   coin_vld      in   1  coin present this cycle
//   coin_code     in   2  00=none, 01=1 unit, 10=2 units, 11=5 units
//   sel_vld       in   1  item selection request
//   sel           in   2  item index
//   cancel        in   1  refund request
//   credit_q      in   4  credit Register output
//   reg_d         out  4  credit Register data input
//   reg_en_n      out  1  credit Register load enable, active low
//   coin_ack      out  1  one-cycle pulse, coin accepted
//   dispense      out  1  one-cycle pulse, release item
//   item          out  2  item index, valid while dispense=1
//   change_pulse  out  1  one-cycle pulse per returned credit unit
//   err           out  1  one-cycle pulse, coin or selection rejected
//   busy          out  1  1 = inputs ignored this cycle
// ---------------------------------------------------------------------------
module vend_credit_ctrl #(
    parameter logic [3:0] PRICE_0    = 4'd3,
    parameter logic [3:0] PRICE_1    = 4'd5,
    parameter logic [3:0] PRICE_2    = 4'd7,
    parameter logic [3:0] PRICE_3    = 4'd9,
    parameter logic [3:0] CREDIT_MAX = 4'd15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       coin_vld,
    input  logic [1:0] coin_code,
    input  logic       sel_vld,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic [3:0] credit_q,
    output logic [3:0] reg_d,
    output logic       reg_en_n,
    output logic       coin_ack,
    output logic       dispense,
    output logic [1:0] item,
    output logic       change_pulse,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        INIT,
        ACCEPT,
        CWR,
        VEND,
        CHK,
        CHG
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] reg_d_nxt;
    logic [1:0] item_nxt;
    logic       err_nxt;

    logic [3:0] price;
    logic [3:0] coin_val;
    logic [4:0] coin_sum;

    // Price of the currently requested item.
    always_comb begin
        price = PRICE_0;
        case (sel)
            2'd0:    price = PRICE_0;
            2'd1:    price = PRICE_1;
            2'd2:    price = PRICE_2;
            2'd3:    price = PRICE_3;
            default: price = PRICE_0;
        endcase
    end

    // Coin value and the new credit it would produce. The sum is one bit
    // wider so that an overflow past 15 is still visible to the limit check.
    always_comb begin
        coin_val = 4'd0;
        case (coin_code)
            2'b01:   coin_val = 4'd1;
            2'b10:   coin_val = 4'd2;
            2'b11:   coin_val = 4'd5;
            default: coin_val = 4'd0;
        endcase
        coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    end

    // Next-state logic and next values for the data-carrying outputs.
    // INIT stays put until its clearing write is actually on the bus.
    // Registered outputs only take effect one cycle after reset is released,
    // so INIT lasts two cycles.
    always_comb begin
        state_nxt = state;
        reg_d_nxt = reg_d;
        item_nxt  = item;
        err_nxt   = 1'b0;
        case (state)
            INIT: begin
                reg_d_nxt = 4'd0;
                if (!reg_en_n) begin
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                if (cancel) begin
                    if (credit_q != 4'd0) begin
                        reg_d_nxt = credit_q - 4'd1;
                        state_nxt = CHG;
                    end
                end else if (sel_vld) begin
                    if (credit_q >= price) begin
                        reg_d_nxt = credit_q - price;
                        item_nxt  = sel;
                        state_nxt = VEND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (coin_vld && (coin_code != 2'b00)) begin
                    if (coin_sum <= {1'b0, CREDIT_MAX}) begin
                        reg_d_nxt = coin_sum[3:0];
                        state_nxt = CWR;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            CWR: begin
                state_nxt = ACCEPT;
            end
            VEND: begin
                state_nxt = CHK;
            end
            CHK: begin
                if (credit_q == 4'd0) begin
                    state_nxt = ACCEPT;
                end else begin
                    reg_d_nxt = credit_q - 4'd1;
                    state_nxt = CHG;
                end
            end
            CHG: begin
                state_nxt = CHK;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // State and output registers. Outputs are computed from the next state,
    // so the write enable and the pulses line up with the state they belong to.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= INIT;
            reg_d        <= 4'd0;
            reg_en_n     <= 1'b1;
            item         <= 2'd0;
            coin_ack     <= 1'b0;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b1;
        end else begin
            state        <= state_nxt;
            reg_d        <= reg_d_nxt;
            item         <= item_nxt;
            reg_en_n     <= !((state_nxt == INIT) || (state_nxt == CWR) ||
                              (state_nxt == VEND) || (state_nxt == CHG));
            coin_ack     <= (state_nxt == CWR);
            dispense     <= (state_nxt == VEND);
            change_pulse <= (state_nxt == CHG);
            err          <= err_nxt;
            busy         <= (state_nxt != ACCEPT);
        end
    end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_credit_ctrl
//
// Purpose:
//   Self-checking bench for vend_credit_ctrl. It models the external credit
//   Register and drives directed scenarios followed by random transactions.
//   A reference model predicts each transaction's pulses into a scoreboard
//   queue, and a monitor pops and compares whenever the DUT pulses.
// ---------------------------------------------------------------------------
module tb_vend_credit_ctrl;

    localparam int EV_ACK  = 0;
    localparam int EV_DISP = 1;
    localparam int EV_CHG  = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int         kind;
        logic [1:0] item;
        int         regd;
        bit         chained;
        int         exp_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       coin_vld = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       sel_vld = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0;
    logic [3:0] credit_q = 4'd9;
    logic [3:0] reg_d;
    logic       reg_en_n;
    logic       coin_ack;
    logic       dispense;
    logic [1:0] item;
    logic       change_pulse;
    logic       err;
    logic       busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   model_credit = 0;
    int   prices [4] = '{3, 5, 7, 9};
    exp_t sb [$];

    vend_credit_ctrl dut (
        .clk          (clk),
        .clr          (clr),
        .coin_vld     (coin_vld),
        .coin_code    (coin_code),
        .sel_vld      (sel_vld),
        .sel          (sel),
        .cancel       (cancel),
        .credit_q     (credit_q),
        .reg_d        (reg_d),
        .reg_en_n     (reg_en_n),
        .coin_ack     (coin_ack),
        .dispense     (dispense),
        .item         (item),
        .change_pulse (change_pulse),
        .err          (err),
        .busy         (busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // External credit Register. It deliberately powers up non-zero, so the
    // clearing write from INIT is visible.
    always_ff @(posedge clk) begin
        if (!reg_en_n) begin
            credit_q <= reg_d;
        end
        cyc <= cyc + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Waits on falling edges until the DUT is idle, with a bounded budget.
    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checkOutput("idle_timeout", 1, 0);
        end
    endtask

    function automatic exp_t mkExp(int kind, logic [1:0] it, int regd, bit chained, int ec);
        exp_t e;
        e.kind    = kind;
        e.item    = it;
        e.regd    = regd;
        e.chained = chained;
        e.exp_cyc = ec;
        return e;
    endfunction

    // Issues one ACCEPT-cycle request and predicts its outcome from the
    // vending rules. The prediction covers credit arithmetic, input priority
    // and the expected pulse train.
    task automatic applyStimulus(input bit c, input bit sv, input logic [1:0] s,
                                 input bit cv, input logic [1:0] cc);
        int base;
        int v;
        waitIdle();
        checkOutput("credit", int'(credit_q), model_credit);
        checkOutput("sb_drained", sb.size(), 0);
        base = cyc + 1;
        if (c) begin
            for (int i = model_credit - 1; i >= 0; i--) begin
                sb.push_back(mkExp(EV_CHG, 2'd0, i, i != model_credit - 1, base));
            end
            model_credit = 0;
        end else if (sv) begin
            if (model_credit >= prices[s]) begin
                model_credit -= prices[s];
                sb.push_back(mkExp(EV_DISP, s, model_credit, 1'b0, base));
                for (int i = model_credit - 1; i >= 0; i--) begin
                    sb.push_back(mkExp(EV_CHG, 2'd0, i, 1'b1, 0));
                end
                model_credit = 0;
            end else begin
                sb.push_back(mkExp(EV_ERR, 2'd0, 0, 1'b0, base));
            end
        end else if (cv && cc != 2'b00) begin
            v = (cc == 2'b01) ? 1 : (cc == 2'b10) ? 2 : 5;
            if (model_credit + v <= 15) begin
                model_credit += v;
                sb.push_back(mkExp(EV_ACK, 2'd0, model_credit, 1'b0, base));
            end else begin
                sb.push_back(mkExp(EV_ERR, 2'd0, 0, 1'b0, base));
            end
        end
        cancel    = c;
        sel_vld   = sv;
        sel       = s;
        coin_vld  = cv;
        coin_code = cc;
        @(negedge clk);
        cancel    = 1'b0;
        sel_vld   = 1'b0;
        coin_vld  = 1'b0;
        coin_code = 2'b00;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_reg_d"}, int'(reg_d), 0);
        checkOutput({tag, "_reg_en_n"}, int'(reg_en_n), 1);
        checkOutput({tag, "_item"}, int'(item), 0);
        checkOutput({tag, "_busy"}, int'(busy), 1);
        checkOutput({tag, "_pulses"}, int'({coin_ack, dispense, change_pulse, err}), 0);
    endtask

    // Monitor: every pulse from the DUT must match the oldest prediction,
    // including its reg_d/reg_en_n side effects and its cycle timing.
    always @(negedge clk) begin
        int   obs;
        exp_t e;
        if (clr && (coin_ack || dispense || change_pulse || err)) begin
            obs = coin_ack ? EV_ACK : dispense ? EV_DISP : change_pulse ? EV_CHG : EV_ERR;
            checkOutput("single_pulse",
                        int'(coin_ack) + int'(dispense) + int'(change_pulse) + int'(err), 1);
            checkOutput("pulse_expected", (sb.size() == 0) ? 0 : 1, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("event_kind", obs, e.kind);
                if (e.kind == EV_ERR) begin
                    checkOutput("err_no_write", int'(reg_en_n), 1);
                end else begin
                    checkOutput("write_en", int'(reg_en_n), 0);
                    checkOutput("write_data", int'(reg_d), e.regd);
                end
                if (e.kind == EV_DISP) begin
                    checkOutput("item", int'(item), int'(e.item));
                end
                checkOutput("event_cycle", cyc, e.chained ? last_cyc + 2 : e.exp_cyc);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        // Reset state, including a register that powers up non-zero.
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        clr = 1'b1;

        // Coin 2 then coin 1 -> credit 3.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b01);
        // Credit 5, buy item 0 -> dispense, then two change units.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'b00);
        // Credit 2, item 1 too expensive -> err.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'b00);
        // Credit 12, coin 5 overflows -> err.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b11);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b11);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b11);
        // Credit 12 + 3 = 15 exactly is accepted; then refund it all.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'b00);
        // Cancel with zero credit and a null coin are both ignored.
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b00);
        // Credit 4 with cancel, select and coin together -> refund 4.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 2'b01);

        // Credit 3, cancel, then reset during the first change unit.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'b00);
        #2;
        checkOutput("mid_reset_in_chg", int'(change_pulse), 1);
        clr = 1'b0;
        #1;
        checkResetOutputs("midreset");
        sb.delete();
        model_credit = 0;
        repeat (3) @(negedge clk);
        checkOutput("held_reset_credit", int'(credit_q), 3);
        clr = 1'b1;

        // Random transactions against the reference model.
        for (int t = 0; t < 120; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'($urandom_range(0, 3)));
            end else if (r <= 7) begin
                applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 2'b00);
            end else if (r == 8) begin
                applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'b00);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                              2'($urandom_range(0, 3)));
            end
        end

        waitIdle();
        checkOutput("final_credit", int'(credit_q), model_credit);
        checkOutput("final_sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
